alu_seq: RTL and testbench

Parametrised, registered successor to the combinational 4-bit ALU. It accepts one operation per valid/ready handshake on WIDTH-bit operands and returns the result and flags through an output valid/ready handshake. AND, OR, NOT, ADD and SUB complete in one cycle. The optional MUL runs as an iterative shift-add over WIDTH cycles. It sits between an operand-issuing controller and a result consumer that may stall.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_mul_iter.sv | 55 +++++
 rtl/alu_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the registered sequential ALU.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
// The product output already includes the step being applied this cycle, so it is final while done is high.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;

    assign acc_d   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign busy    = busy_q;
    assign done    = busy_q & (cnt_q == LAST_STEP);
    assign product = acc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            acc_q    <= '0;
            mplier_q <= b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides; single-cycle logic/arith ops.
// Define ALU_SEQ_MUL_EN to build the iterative MUL path (BUSY state, ALU_Out_Hi generation).
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALU_Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Out,
    output logic [WIDTH-1:0] ALU_Out_Hi,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Zero,
    output logic             Err
);

    state_e state_q, state_d;
    logic   accept;
    logic   load_single;
    logic   ready_base;

    logic [WIDTH-1:0] out_q;
    logic             carry_q, ovf_q, zero_q, err_q;

    logic [WIDTH:0]   sum_ext, diff_ext;
    logic [WIDTH-1:0] res_lo;
    logic             res_c, res_v, res_err;

    assign ready_base = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    assign accept     = in_valid & in_ready;
    assign out_valid  = (state_q == ST_DONE);

    assign sum_ext  = {1'b0, A} + {1'b0, B};
    assign diff_ext = {1'b0, A} - {1'b0, B};

    always_comb begin
        res_lo  = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_err = 1'b0;
        case (ALU_Sel)
            OP_AND: res_lo = A & B;
            OP_OR:  res_lo = A | B;
            OP_NOT: res_lo = ~A;
            OP_ADD: begin
                res_lo = sum_ext[WIDTH-1:0];
                res_c  = sum_ext[WIDTH];
                res_v  = (A[WIDTH-1] == B[WIDTH-1]) & (sum_ext[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                // diff_ext[WIDTH] is the unsigned borrow, i.e. A < B
                res_lo = diff_ext[WIDTH-1:0];
                res_c  = diff_ext[WIDTH];
                res_v  = (A[WIDTH-1] != B[WIDTH-1]) & (diff_ext[WIDTH-1] != A[WIDTH-1]);
            end
            default: res_err = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic               mul_start, mul_busy, mul_done, load_mul;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH-1:0]   hi_q;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Multiplier occupancy also blocks intake, guarding against any state/engine skew.
    assign in_ready   = ready_base & ~mul_busy;
    assign ALU_Out_Hi = hi_q;
`else
    assign in_ready   = ready_base;
    assign ALU_Out_Hi = '0;
`endif

    always_comb begin
        state_d     = state_q;
        load_single = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        mul_start   = 1'b0;
        load_mul    = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                    if (ALU_Sel == OP_MUL) begin
                        state_d   = ST_BUSY;
                        mul_start = 1'b1;
                    end else
`endif
                    begin
                        state_d     = ST_DONE;
                        load_single = 1'b1;
                    end
                end else if ((state_q == ST_DONE) && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            ST_BUSY: begin
                if (mul_done) begin
                    state_d  = ST_DONE;
                    load_mul = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            hi_q    <= '0;
`endif
        end else if (load_single) begin
            out_q   <= res_lo;
            carry_q <= res_c;
            ovf_q   <= res_v;
            zero_q  <= (res_lo == '0);
            err_q   <= res_err;
`ifdef ALU_SEQ_MUL_EN
            hi_q    <= '0;
        end else if (load_mul) begin
            out_q   <= mul_product[WIDTH-1:0];
            hi_q    <= mul_product[2*WIDTH-1:WIDTH];
            carry_q <= |mul_product[2*WIDTH-1:WIDTH];
            ovf_q   <= 1'b0;
            zero_q  <= (mul_product[WIDTH-1:0] == '0);
            err_q   <= 1'b0;
`endif
        end
    end

    assign ALU_Out  = out_q;
    assign CarryOut = carry_q;
    assign Overflow = ovf_q;
    assign Zero     = zero_q;
    assign Err      = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8); MUL expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A, B;
    logic [2:0]   ALU_Sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALU_Out, ALU_Out_Hi;
    logic         CarryOut, Overflow, Zero, Err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .ALU_Sel    (ALU_Sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALU_Out    (ALU_Out),
        .ALU_Out_Hi (ALU_Out_Hi),
        .CarryOut   (CarryOut),
        .Overflow   (Overflow),
        .Zero       (Zero),
        .Err        (Err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = v;
        ALU_Sel  = op;
        A        = a;
        B        = b;
    endtask

    task automatic chk_res(input string tag, input logic [W-1:0] o, input logic c,
                           input logic v, input logic z, input logic e);
        chk({tag, ".vld"}, 16'(out_valid), 16'd1);
        chk({tag, ".out"}, 16'(ALU_Out), 16'(o));
        chk({tag, ".c"},   16'(CarryOut), 16'(c));
        chk({tag, ".v"},   16'(Overflow), 16'(v));
        chk({tag, ".z"},   16'(Zero), 16'(z));
        chk({tag, ".err"}, 16'(Err), 16'(e));
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 3'b000, '0, '0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst.in_ready", 16'(in_ready), 16'd1);
        chk("rst.out_valid", 16'(out_valid), 16'd0);
        chk("rst.out", 16'(ALU_Out), 16'h0);
        chk("rst.hi", 16'(ALU_Out_Hi), 16'h0);
        chk("rst.flags", {12'd0, CarryOut, Overflow, Zero, Err}, 16'h0);

`ifdef ALU_SEQ_MUL_EN
        // Reset while BUSY discards the product
        out_ready = 1'b1;
        drive(1'b1, 3'b101, 8'd200, 8'd3);
        tick();
        drive(1'b0, 3'b000, '0, '0);
        for (int i = 0; i < 3; i++) begin
            chk("rm.busy_vld", 16'(out_valid), 16'd0);
            tick();
        end
        rst = 1'b1;
        #1;
        chk("rm.vld_in_rst", 16'(out_valid), 16'd0);
        tick();
        rst = 1'b0;
        chk("rm.in_ready", 16'(in_ready), 16'd1);
        chk("rm.out", 16'(ALU_Out), 16'h0);
        chk("rm.hi", 16'(ALU_Out_Hi), 16'h0);
        for (int i = 0; i < W + 2; i++) begin
            chk("rm.no_vld", 16'(out_valid), 16'd0);
            tick();
        end
`endif

        // Reset while DONE discards the held result
        out_ready = 1'b0;
        drive(1'b1, 3'b011, 8'd1, 8'd1);
        tick();
        drive(1'b0, 3'b000, '0, '0);
        chk("rd.vld", 16'(out_valid), 16'd1);
        rst = 1'b1;
        #1;
        chk("rd.vld_gone", 16'(out_valid), 16'd0);
        chk("rd.out", 16'(ALU_Out), 16'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("rd.no_vld", 16'(out_valid), 16'd0);
        chk("rd.in_ready", 16'(in_ready), 16'd1);

        // ADD / SUB back-to-back with out_ready high
        out_ready = 1'b1;
        drive(1'b1, 3'b011, 8'd255, 8'd1);
        tick();
        drive(1'b1, 3'b011, 8'd127, 8'd1);
        chk_res("add255_1", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("b2b.in_ready", 16'(in_ready), 16'd1);
        tick();
        drive(1'b1, 3'b100, 8'd3, 8'd5);
        chk_res("add127_1", 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'b100, 8'd5, 8'd3);
        chk_res("sub3_5", 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'b100, 8'h80, 8'h01);
        chk_res("sub5_3", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 3'b000, '0, '0);
        chk_res("sub80_1", 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("b2b.idle_vld", 16'(out_valid), 16'd0);

        // MUL 200*3
        drive(1'b1, 3'b101, 8'd200, 8'd3);
        tick();
        drive(1'b0, 3'b000, '0, '0);
`ifdef ALU_SEQ_MUL_EN
        for (int i = 0; i < W; i++) begin
            chk("mul.busy_rdy", 16'(in_ready), 16'd0);
            chk("mul.busy_vld", 16'(out_valid), 16'd0);
            tick();
        end
        chk_res("mul200_3", 8'h58, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mul.hi", 16'(ALU_Out_Hi), 16'h02);
`else
        chk_res("mul_off", 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("mul_off.hi", 16'(ALU_Out_Hi), 16'h00);
`endif
        tick();
        chk("mul.idle_vld", 16'(out_valid), 16'd0);

        // Backpressure: result held, further requests ignored until out_ready
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 8'hAA, 8'hCC);
        tick();
        drive(1'b1, 3'b001, 8'h01, 8'h02);
        for (int i = 0; i < 5; i++) begin
            chk("bp.out", 16'(ALU_Out), 16'h88);
            chk("bp.vld", 16'(out_valid), 16'd1);
            chk("bp.in_ready", 16'(in_ready), 16'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_rdy", 16'(in_ready), 16'd1);
        tick();
        drive(1'b0, 3'b000, '0, '0);
        chk_res("bp.or", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Invalid opcode and NOT
        drive(1'b1, 3'b111, 8'h5A, 8'h33);
        tick();
        drive(1'b1, 3'b010, 8'h0F, 8'h00);
        chk_res("inv111", 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("inv111.hi", 16'(ALU_Out_Hi), 16'h00);
        tick();
        drive(1'b0, 3'b000, '0, '0);
        chk_res("not0F", 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("end.idle_vld", 16'(out_valid), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
